// File: rtl/synth_pkg.sv
// Shared definitions for the potentiometer ADC scanner.
// Contents: scanner state encoding, SPI frame geometry constants, and
// the MCP3008 command-bit lookup used to drive MOSI.
package synth_pkg;

  localparam int unsigned FRAME_BITS      = 17;  // SCLK periods per frame
  localparam int unsigned DATA_FIRST_EDGE = 8;   // rising edge carrying B9
  localparam int unsigned ADC_W           = 10;

  typedef enum logic [2:0] {
    ST_GAP,
    ST_CS_SETUP,
    ST_SHIFT,
    ST_CS_HOLD,
    ST_UPDATE
  } scan_state_e;

  // MOSI level for SCLK period 1..17: start, single-ended, D2..D0, then zeros.
  function automatic logic cmd_bit(input logic [4:0] period, input logic [2:0] ch);
    case (period)
      5'd1, 5'd2: cmd_bit = 1'b1;
      5'd3:       cmd_bit = ch[2];
      5'd4:       cmd_bit = ch[1];
      5'd5:       cmd_bit = ch[0];
      default:    cmd_bit = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/pot_adc_scanner_spi_clk_gen.sv
// SPI clock generator: half-period tick every CLK_DIV clks while enabled.
// Ports:
//   clk, rst       system clock, synchronous active-high reset
//   en             run the divider; when low the divider and SCLK are cleared
//   toggle_en      allow the tick to toggle SCLK
//   tick           one-clk strobe at the end of each half-period
//   sclk           SCLK level (idle low)
//   sclk_rise/fall one-clk strobes on the clk edge where SCLK rises/falls
module spi_clk_gen #(
  parameter int unsigned CLK_DIV = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic toggle_en,
  output logic tick,
  output logic sclk,
  output logic sclk_rise,
  output logic sclk_fall
);

  localparam int unsigned CNT_W = $clog2(CLK_DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sclk_q, sclk_d;

  always_comb begin
    tick      = en && (cnt_q == CNT_W'(CLK_DIV - 1));
    sclk_rise = tick && toggle_en && !sclk_q;
    sclk_fall = tick && toggle_en && sclk_q;
    cnt_d     = cnt_q;
    sclk_d    = sclk_q;
    if (!en) begin
      cnt_d  = '0;
      sclk_d = 1'b0;
    end else begin
      cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
      if (tick && toggle_en) sclk_d = ~sclk_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

  assign sclk = sclk_q;

endmodule

// File: rtl/pot_adc_scanner.sv
// Potentiometer scanner: reads two channels of an MCP3008-class SPI ADC
// round-robin and presents hysteresis-filtered 10-bit readings.
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   adc_cs_n/sclk/mosi  SPI master outputs (mode 0,0)
//   adc_miso            ADC data, asynchronous, double-registered here
//   P0, P1              filtered readings for CH0_SEL / CH1_SEL
//   sample_valid        one-clk pulse per completed frame
//   sample_ch           channel index of that frame (0 = P0, 1 = P1)
module pot_adc_scanner #(
  parameter int unsigned CLK_DIV = 25,
  parameter int unsigned CH0_SEL = 0,
  parameter int unsigned CH1_SEL = 1,
  parameter int unsigned HYST    = 4,
  parameter int unsigned GAP_CYC = 1000
) (
  input  logic       clk,
  input  logic       rst,
  output logic       adc_cs_n,
  output logic       adc_sclk,
  output logic       adc_mosi,
  input  logic       adc_miso,
  output logic [9:0] P0,
  output logic [9:0] P1,
  output logic       sample_valid,
  output logic       sample_ch
);
  import synth_pkg::*;

  localparam int unsigned GAP_W = $clog2(GAP_CYC + 1);

  scan_state_e      state_q, state_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [4:0]       rise_cnt_q, rise_cnt_d;
  logic [ADC_W-1:0] shift_q, shift_d;
  logic [ADC_W-1:0] p0_q, p0_d, p1_q, p1_d;
  logic             mosi_q, mosi_d;
  logic             cs_n_q, cs_n_d;
  logic             ch_ptr_q, ch_ptr_d;
  logic             sv_q, sv_d;
  logic             sch_q, sch_d;
  logic             miso_meta_q, miso_sync_q;

  logic             clk_en, toggle_en, tick, sclk, sclk_rise, sclk_fall;
  logic [2:0]       frame_ch;
  logic [ADC_W-1:0] cur;
  logic signed [ADC_W:0] diff;
  logic [ADC_W:0]   mag;
  logic             upd;

  assign clk_en    = state_q inside {ST_CS_SETUP, ST_SHIFT, ST_CS_HOLD};
  assign toggle_en = (state_q == ST_SHIFT);
  assign frame_ch  = ch_ptr_q ? 3'(CH1_SEL) : 3'(CH0_SEL);

  spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk       (clk),
    .rst       (rst),
    .en        (clk_en),
    .toggle_en (toggle_en),
    .tick      (tick),
    .sclk      (sclk),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall)
  );

  // Hysteresis: 11-bit signed difference so 0..1023 never wraps.
  always_comb begin
    cur  = ch_ptr_q ? p1_q : p0_q;
    diff = $signed({1'b0, shift_q}) - $signed({1'b0, cur});
    mag  = diff[ADC_W] ? 11'(-diff) : 11'(diff);
    upd  = (mag >= 11'(HYST)) || (shift_q == '0) || (shift_q == '1);
  end

  always_comb begin
    state_d    = state_q;
    gap_cnt_d  = gap_cnt_q;
    rise_cnt_d = rise_cnt_q;
    shift_d    = shift_q;
    mosi_d     = mosi_q;
    ch_ptr_d   = ch_ptr_q;
    p0_d       = p0_q;
    p1_d       = p1_q;
    sv_d       = 1'b0;
    sch_d      = sch_q;
    case (state_q)
      ST_GAP: begin
        if (gap_cnt_q == GAP_W'(GAP_CYC - 1)) begin
          state_d    = ST_CS_SETUP;
          gap_cnt_d  = '0;
          rise_cnt_d = '0;
          mosi_d     = cmd_bit(5'd1, frame_ch);
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      ST_CS_SETUP: begin
        if (tick) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (sclk_rise) begin
          rise_cnt_d = rise_cnt_q + 5'd1;
          if (rise_cnt_q >= 5'(DATA_FIRST_EDGE - 1)) shift_d = {shift_q[ADC_W-2:0], miso_sync_q};
        end
        // MOSI advances on the falling edge so it is settled for the next rise.
        if (sclk_fall) begin
          mosi_d = cmd_bit(rise_cnt_q + 5'd1, frame_ch);
          if (rise_cnt_q == 5'(FRAME_BITS)) state_d = ST_CS_HOLD;
        end
      end
      ST_CS_HOLD: begin
        if (tick) state_d = ST_UPDATE;
      end
      ST_UPDATE: begin
        sv_d     = 1'b1;
        sch_d    = ch_ptr_q;
        ch_ptr_d = ~ch_ptr_q;
        if (upd) begin
          if (ch_ptr_q) p1_d = shift_q;
          else          p0_d = shift_q;
        end
        state_d = ST_GAP;
      end
      default: state_d = ST_GAP;
    endcase
    cs_n_d = !(state_d inside {ST_CS_SETUP, ST_SHIFT, ST_CS_HOLD});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_GAP;
      gap_cnt_q   <= '0;
      rise_cnt_q  <= '0;
      shift_q     <= '0;
      mosi_q      <= 1'b0;
      cs_n_q      <= 1'b1;
      ch_ptr_q    <= 1'b0;
      p0_q        <= '0;
      p1_q        <= '0;
      sv_q        <= 1'b0;
      sch_q       <= 1'b0;
      miso_meta_q <= 1'b0;
      miso_sync_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      gap_cnt_q   <= gap_cnt_d;
      rise_cnt_q  <= rise_cnt_d;
      shift_q     <= shift_d;
      mosi_q      <= mosi_d;
      cs_n_q      <= cs_n_d;
      ch_ptr_q    <= ch_ptr_d;
      p0_q        <= p0_d;
      p1_q        <= p1_d;
      sv_q        <= sv_d;
      sch_q       <= sch_d;
      miso_meta_q <= adc_miso;
      miso_sync_q <= miso_meta_q;
    end
  end

  assign adc_cs_n     = cs_n_q;
  assign adc_sclk     = sclk;
  assign adc_mosi     = mosi_q;
  assign P0           = p0_q;
  assign P1           = p1_q;
  assign sample_valid = sv_q;
  assign sample_ch    = sch_q;

endmodule

// File: tb/tb_pot_adc_scanner.sv
module tb_pot_adc_scanner;

  localparam int CLK_DIV = 25;
  localparam int GAP_CYC = 40;
  localparam int HYST    = 4;
  localparam int CH0     = 5;
  localparam int CH1     = 7;
  localparam int FRAME_CLKS = 36 * CLK_DIV + GAP_CYC + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       adc_miso = 1'b0;
  logic       adc_cs_n, adc_sclk, adc_mosi, sample_valid, sample_ch;
  logic [9:0] P0, P1;

  pot_adc_scanner #(
    .CLK_DIV (CLK_DIV),
    .CH0_SEL (CH0),
    .CH1_SEL (CH1),
    .HYST    (HYST),
    .GAP_CYC (GAP_CYC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .adc_cs_n     (adc_cs_n),
    .adc_sclk     (adc_sclk),
    .adc_mosi     (adc_mosi),
    .adc_miso     (adc_miso),
    .P0           (P0),
    .P1           (P1),
    .sample_valid (sample_valid),
    .sample_ch    (sample_ch)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference state: ADC channel contents, expected filtered outputs,
  // expected channel pointer, and values returned by completed frames.
  int adc_val [8];
  int m_p [2];
  int m_ptr = 0;
  int fq [$];
  int frames_done = 0;
  int rises = 0;

  // ADC + protocol model, sampled on the falling clk edge.
  initial begin : adc_model
    logic prev_cs = 1'b1, prev_sclk = 1'b0, prev_mosi = 1'b0, prev_sv = 1'b0;
    logic [9:0] prev_p0 = '0, prev_p1 = '0;
    logic mos [1:17];
    bit active = 0;
    int since = 0, fval = 0, ch = 0, ones = 0, nv = 0, c = 0, d = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        active = 0; rises = 0; m_p[0] = 0; m_p[1] = 0; m_ptr = 0;
        fq.delete(); adc_miso = 1'b0;
      end else begin
        if (active) since++;
        if (prev_cs && !adc_cs_n) begin
          active = 1; rises = 0; since = 0;
          for (int i = 1; i <= 17; i++) mos[i] = 1'b0;
        end
        if (active && !prev_sclk && adc_sclk) begin
          check_eq("sclk_low_len", since, (rises == 0) ? 2 * CLK_DIV : CLK_DIV);
          check_eq("mosi_stable_at_rise", adc_mosi, prev_mosi);
          rises++;
          if (rises <= 17) mos[rises] = adc_mosi;
          since = 0;
        end
        if (active && prev_sclk && !adc_sclk) begin
          check_eq("sclk_high_len", since, CLK_DIV);
          since = 0;
          if (rises == 7) begin
            ch   = int'({mos[3], mos[4], mos[5]});
            fval = adc_val[ch];
          end
          // ADC shifts B9..B0 out ahead of rising edges 8..17; other bits are junk.
          if (rises >= 7 && rises <= 16) adc_miso = fval[16 - rises];
          else adc_miso = 1'($urandom);
        end
        if (active && !prev_cs && adc_cs_n) begin
          check_eq("rises_per_frame", rises, 17);
          check_eq("cs_hold_len", since, CLK_DIV);
          check_eq("cmd_start", mos[1], 1);
          check_eq("cmd_sgl", mos[2], 1);
          check_eq("cmd_channel", int'({mos[3], mos[4], mos[5]}), m_ptr ? CH1 : CH0);
          ones = 0;
          for (int i = 6; i <= 17; i++) ones += int'(mos[i]);
          check_eq("cmd_tail_zero", ones, 0);
          fq.push_back(fval);
          active = 0;
        end
        if (sample_valid) begin
          check_eq("sv_single_pulse", prev_sv, 0);
          check_eq("sample_ch", sample_ch, m_ptr);
          check_eq("frames_pending", fq.size(), 1);
          nv = (fq.size() > 0) ? fq.pop_front() : -1;
          c  = m_ptr;
          d  = nv - m_p[c];
          if (d < 0) d = -d;
          if (d >= HYST || nv == 0 || nv == 1023) m_p[c] = nv;
          m_ptr = 1 - m_ptr;
          check_eq("p0_after_frame", P0, m_p[0]);
          check_eq("p1_after_frame", P1, m_p[1]);
          frames_done++;
        end else begin
          check_eq("p0_hold", P0, prev_p0);
          check_eq("p1_hold", P1, prev_p1);
        end
      end
      prev_cs = adc_cs_n; prev_sclk = adc_sclk; prev_mosi = adc_mosi;
      prev_sv = sample_valid; prev_p0 = P0; prev_p1 = P1;
    end
  end

  task automatic wait_frames(input int n);
    int target = frames_done + n;
    int budget = n * (FRAME_CLKS + 20);
    while (frames_done < target && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check_eq("frames_seen", frames_done, target);
  endtask

  task automatic measure_gap(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (adc_cs_n && n < GAP_CYC + 50);
    check_eq(tag, n, GAP_CYC);
  endtask

  task automatic step(input int v0, input int v1, input int e0, input int e1);
    adc_val[CH0] = v0;
    adc_val[CH1] = v1;
    wait_frames(2);
    check_eq("p0_value", P0, e0);
    check_eq("p1_value", P1, e1);
  endtask

  function automatic int pick(input int cur);
    int v;
    case ($urandom_range(0, 3))
      0: v = $urandom_range(0, 1023);
      1: v = ($urandom_range(0, 1) != 0) ? 1023 : 0;
      default: v = cur + $urandom_range(0, 16) - 8;
    endcase
    if (v < 0) v = 0;
    if (v > 1023) v = 1023;
    return v;
  endfunction

  initial begin : main
    int budget;
    for (int i = 0; i < 8; i++) adc_val[i] = $urandom_range(0, 1023);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_cs_n", adc_cs_n, 1);
    check_eq("rst_sclk", adc_sclk, 0);
    check_eq("rst_mosi", adc_mosi, 0);
    check_eq("rst_p0", P0, 0);
    check_eq("rst_p1", P1, 0);
    check_eq("rst_sv", sample_valid, 0);
    check_eq("rst_sch", sample_ch, 0);
    rst = 1'b0;
    measure_gap("gap_after_reset");

    step(12'h2A5, 12'h155, 12'h2A5, 12'h155);
    step(100, 900, 100, 900);
    step(100, 900, 100, 900);
    step(500, 903, 500, 900);
    step(503, 896, 500, 896);
    step(504, 896, 504, 896);
    step(1021, 896, 1021, 896);
    step(1023, 1, 1023, 1);
    step(2, 0, 2, 0);
    step(0, 3, 0, 0);
    step(1, 1020, 0, 1020);
    step(1, 1022, 0, 1020);

    for (int k = 0; k < 8; k++) begin
      adc_val[CH0] = pick(m_p[0]);
      adc_val[CH1] = pick(m_p[1]);
      wait_frames(2);
    end

    // Abort a frame partway through the data phase.
    adc_val[CH0] = 777;
    budget = 2 * FRAME_CLKS;
    while (!(rises == 10 && !adc_cs_n) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check_eq("reached_rise10", rises, 10);
    rst = 1'b1;
    @(negedge clk);
    check_eq("midrst_cs_n", adc_cs_n, 1);
    check_eq("midrst_sclk", adc_sclk, 0);
    check_eq("midrst_mosi", adc_mosi, 0);
    check_eq("midrst_p0", P0, 0);
    check_eq("midrst_p1", P1, 0);
    check_eq("midrst_sv", sample_valid, 0);
    repeat (2) @(negedge clk);
    check_eq("midrst_sv_held", sample_valid, 0);
    rst = 1'b0;
    measure_gap("gap_after_midreset");
    step(321, 654, 321, 654);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
